gray_weight_arb: RTL and testbench

Owns the single-port gray-filter weight table (2^AW × DW) and shares it between two requesters: the pixel-rate filter lookup port and the configuration port that rewrites weights at run time. After reset it fills the whole table with a default weight, then grants every filter read immediately and commits configuration writes only on cycles with no filter read. It sits between the gray filter datapath and the register/config bus, replacing a fixed ROM.

---
 rtl/gray_weight_arb.sv | 199 +++++++++++++++++++
 tb/tb_gray_weight_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_weight_arb.sv
`default_nettype none
// ============================================================================
//  Module   : gray_weight_arb
//  Purpose  : Single-port gray-filter weight table shared by the pixel-rate
//             lookup port (highest priority) and a one-entry buffered
//             configuration port. The table is filled with INIT_DATA after
//             every reset.
//  Option   : GRAY_WT_READBACK_EN - config requests with i_Cfg_we = 0 read
//             the table back through o_Cfg_rvalid / o_Cfg_rdata.
//  Revision : 1.0 - initial release
// ============================================================================
module gray_weight_arb #(
    parameter int              DW         = 12,
    parameter int              AW         = 9,
    parameter logic [DW-1:0]   INIT_DATA  = {DW{1'b0}},
    parameter logic [15:0]     STARVE_MAX = 16'd1024
) (
    input  logic               i_Sys_clk,
    input  logic               i_Rst,
    input  logic               i_Rd_req,
    input  logic [AW-1:0]      i_Rd_addr,
    output logic               o_Rd_valid,
    output logic [DW-1:0]      o_Rd_data,
    input  logic               i_Cfg_valid,
    output logic               o_Cfg_ready,
    input  logic               i_Cfg_we,
    input  logic [AW-1:0]      i_Cfg_addr,
    input  logic [DW-1:0]      i_Cfg_wdata,
    output logic               o_Cfg_rvalid,
    output logic [DW-1:0]      o_Cfg_rdata,
    output logic               o_Init_done,
    output logic               o_Starve
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [AW-1:0]     r_init_addr;
    logic              r_init_done;
    logic              r_buf_full;
    logic [AW-1:0]     r_buf_addr;
    logic [DW-1:0]     r_buf_wdata;
    logic [15:0]       r_starve_cnt;
    logic [15:0]       w_starve_cnt_nxt;
    logic              r_starve;
    logic              r_rd_valid;
    logic [DW-1:0]     r_rd_data;
    logic [DW-1:0]     r_mem [DEPTH];

    logic              w_init_last;
    logic              w_cfg_ready;
    logic              w_cfg_accept;
    logic              w_rd_grant;
    logic              w_commit;
    logic              w_commit_wr;
    logic              w_ram_we;
    logic [AW-1:0]     w_ram_addr;
    logic [DW-1:0]     w_ram_wdata;

    // Arbitration: filter reads always win; the buffered config request
    // commits only on a cycle with no read. Reset blocks any RAM access so a
    // discarded request can never land in the table.
    assign w_init_last  = (r_state == ST_INIT) && (r_init_addr == {AW{1'b1}});
    assign w_cfg_ready  = r_init_done & ~r_buf_full;
    assign w_cfg_accept = i_Cfg_valid & w_cfg_ready;
    assign w_rd_grant   = r_init_done & i_Rd_req & ~i_Rst;
    assign w_commit     = r_init_done & r_buf_full & ~i_Rd_req & ~i_Rst;

    assign w_ram_we    = ((r_state == ST_INIT) & ~i_Rst) | w_commit_wr;
    assign w_ram_addr  = (r_state == ST_INIT) ? r_init_addr :
                         (i_Rd_req ? i_Rd_addr : r_buf_addr);
    assign w_ram_wdata = (r_state == ST_INIT) ? INIT_DATA : r_buf_wdata;

    assign w_starve_cnt_nxt = (r_starve_cnt == STARVE_MAX) ? r_starve_cnt
                                                           : r_starve_cnt + 16'd1;

    // State register
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    // Next state: leave INIT once the last address has been written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Init sweep address and the done flag, which lags RUN by one cycle
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_init_addr <= {AW{1'b0}};
            r_init_done <= 1'b0;
        end else begin
            if (r_state == ST_INIT) r_init_addr <= r_init_addr + 1'b1;
            r_init_done <= (r_state == ST_RUN);
        end
    end

    // Config holding buffer occupancy
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst)             r_buf_full <= 1'b0;
        else if (w_commit)     r_buf_full <= 1'b0;
        else if (w_cfg_accept) r_buf_full <= 1'b1;
    end

    // Config holding buffer payload (only meaningful while full)
    always_ff @(posedge i_Sys_clk) begin
        if (w_cfg_accept) begin
            r_buf_addr  <= i_Cfg_addr;
            r_buf_wdata <= i_Cfg_wdata;
        end
    end

    // Starvation: saturating wait counter per request, sticky flag
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_starve_cnt <= 16'd0;
            r_starve     <= 1'b0;
        end else begin
            if (w_commit)        r_starve_cnt <= 16'd0;
            else if (r_buf_full) r_starve_cnt <= w_starve_cnt_nxt;
            if (r_buf_full && !w_commit && (w_starve_cnt_nxt == STARVE_MAX))
                r_starve <= 1'b1;
        end
    end

    // Weight table write port
    always_ff @(posedge i_Sys_clk) begin
        if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
    end

    // Filter lookup result, one cycle after the request
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {DW{1'b0}};
        end else begin
            r_rd_valid <= w_rd_grant;
            if (w_rd_grant) r_rd_data <= r_mem[w_ram_addr];
        end
    end

`ifdef GRAY_WT_READBACK_EN
    logic              r_buf_we;
    logic              w_commit_rd;
    logic              r_cfg_rvalid;
    logic [DW-1:0]     r_cfg_rdata;

    assign w_commit_wr = w_commit &  r_buf_we;
    assign w_commit_rd = w_commit & ~r_buf_we;

    // Remember whether the buffered request is a write or a readback
    always_ff @(posedge i_Sys_clk) begin
        if (w_cfg_accept) r_buf_we <= i_Cfg_we;
    end

    // Readback data, one cycle after the read commit
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_rdata  <= {DW{1'b0}};
        end else begin
            r_cfg_rvalid <= w_commit_rd;
            if (w_commit_rd) r_cfg_rdata <= r_mem[w_ram_addr];
        end
    end

    assign o_Cfg_rvalid = r_cfg_rvalid;
    assign o_Cfg_rdata  = r_cfg_rdata;
`else
    logic              w_unused_cfg_we;

    // Every config request is a write; the write-enable input has no effect
    assign w_commit_wr     = w_commit;
    assign w_unused_cfg_we = i_Cfg_we;
    assign o_Cfg_rvalid    = 1'b0;
    assign o_Cfg_rdata     = {DW{1'b0}};
`endif

    assign o_Rd_valid  = r_rd_valid;
    assign o_Rd_data   = r_rd_data;
    assign o_Cfg_ready = w_cfg_ready;
    assign o_Init_done = r_init_done;
    assign o_Starve    = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_gray_weight_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_weight_arb
//  Purpose  : Directed self-checking bench for gray_weight_arb
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_weight_arb;

    localparam int          DW     = 12;
    localparam int          AW     = 9;
    localparam logic [11:0] T_INIT = 12'h3C5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_rvalid;
    logic [DW-1:0] cfg_rdata;
    logic          init_done;
    logic          starve;

    int n_checks = 0;
    int n_errors = 0;

    gray_weight_arb #(
        .DW         (DW),
        .AW         (AW),
        .INIT_DATA  (T_INIT),
        .STARVE_MAX (16'd16)
    ) dut (
        .i_Sys_clk    (clk),
        .i_Rst        (rst),
        .i_Rd_req     (rd_req),
        .i_Rd_addr    (rd_addr),
        .o_Rd_valid   (rd_valid),
        .o_Rd_data    (rd_data),
        .i_Cfg_valid  (cfg_valid),
        .o_Cfg_ready  (cfg_ready),
        .i_Cfg_we     (cfg_we),
        .i_Cfg_addr   (cfg_addr),
        .i_Cfg_wdata  (cfg_wdata),
        .o_Cfg_rvalid (cfg_rvalid),
        .o_Cfg_rdata  (cfg_rdata),
        .o_Init_done  (init_done),
        .o_Starve     (starve)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single filter read; checks valid and data one cycle later
    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req  = 1'b0;
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk({tag, "_data"}, {20'd0, rd_data}, {20'd0, exp});
    endtask

    // Present one config request and hold it until accepted (bounded)
    task automatic cfg(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        chk("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_we    = we;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int gaps;
        int bad;
        int rv_seen;

        rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
        cfg_valid = 1'b0; cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = '0;

        // ---------------- reset state ----------------
        step(); step(); step();
        chk("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
        chk("rst_rd_data",    {20'd0, rd_data},    32'd0);
        chk("rst_cfg_ready",  {31'd0, cfg_ready},  32'd0);
        chk("rst_cfg_rvalid", {31'd0, cfg_rvalid}, 32'd0);
        chk("rst_cfg_rdata",  {20'd0, cfg_rdata},  32'd0);
        chk("rst_init_done",  {31'd0, init_done},  32'd0);
        chk("rst_starve",     {31'd0, starve},     32'd0);

        // ---------------- init sweep: reads ignored, done after 513 ----------------
        rst = 1'b0;
        rd_req = 1'b1;
        n = 0; rv_seen = 0;
        while (!init_done && n < 2000) begin
            step();
            n++;
            if (rd_valid) rv_seen++;
            if (cfg_ready && !init_done) rv_seen++;
        end
        rd_req = 1'b0;
        chk("init_cycles", n, 32'd513);
        chk("init_no_rd_valid", rv_seen, 32'd0);
        chk("init_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        rd("rd_0",   9'd0,   T_INIT);
        rd("rd_255", 9'd255, T_INIT);
        rd("rd_511", 9'd511, T_INIT);

        // ---------------- 640 back-to-back reads ----------------
        gaps = 0; bad = 0;
        for (int i = 0; i < 640; i++) begin
            rd_req  = 1'b1;
            rd_addr = AW'(i % 512);
            step();
            if (!rd_valid) gaps++;
            if (rd_data !== T_INIT) bad++;
        end
        chk("burst_gaps", gaps, 32'd0);
        chk("burst_data", bad, 32'd0);

        // ---------------- write held off by reads, commits on idle ----------------
        rd_addr = 9'h01A;
        cfg(1'b1, 9'h01A, 12'hABC);
        chk("wr_buf_full_ready", {31'd0, cfg_ready}, 32'd0);
        step();
        chk("pre_commit_valid", {31'd0, rd_valid}, 32'd1);
        chk("pre_commit_data", {20'd0, rd_data}, {20'd0, T_INIT});
        chk("wr_still_held", {31'd0, cfg_ready}, 32'd0);
        rd_req = 1'b0;
        step();
        chk("commit_idle_valid", {31'd0, rd_valid}, 32'd0);
        chk("commit_ready_back", {31'd0, cfg_ready}, 32'd1);
        rd("post_commit_1a", 9'h01A, 12'hABC);
        rd("neighbour_1b",   9'h01B, T_INIT);
        chk("no_starve_yet", {31'd0, starve}, 32'd0);

        // ---------------- starvation under continuous reads ----------------
        rd_req = 1'b1; rd_addr = 9'h000;
        cfg(1'b1, 9'h040, 12'h123);
        gaps = 0;
        for (int k = 1; k <= 20; k++) begin
            rd_req  = 1'b1;
            rd_addr = AW'(k);
            step();
            if (!rd_valid) gaps++;
            if (k == 15) chk("starve_at_15", {31'd0, starve}, 32'd0);
            if (k == 16) chk("starve_at_16", {31'd0, starve}, 32'd1);
        end
        chk("starve_rd_gaps", gaps, 32'd0);
        rd_req = 1'b0;
        step();
        chk("starve_sticky", {31'd0, starve}, 32'd1);
        rd("starve_wr_40", 9'h040, 12'h123);

        // ---------------- mid-run reset discards buffered write ----------------
        rd_req = 1'b1; rd_addr = 9'h100;
        cfg(1'b1, 9'h01A, 12'h777);
        step();
        rst = 1'b1; rd_req = 1'b0;
        step();
        rst = 1'b0;
        chk("mrst_starve",    {31'd0, starve},    32'd0);
        chk("mrst_ready",     {31'd0, cfg_ready}, 32'd0);
        chk("mrst_init_done", {31'd0, init_done}, 32'd0);
        n = 0;
        while (!cfg_ready && n < 2000) begin
            step();
            n++;
        end
        chk("mrst_ready_cycles", n, 32'd513);
        rd("mrst_1a",  9'h01A, T_INIT);
        rd("mrst_40",  9'h040, T_INIT);
        rd("mrst_1ff", 9'h1FF, T_INIT);

        // ---------------- readback / we ignored ----------------
        cfg(1'b1, 9'h01A, 12'h5A5);
        step();
`ifdef GRAY_WT_READBACK_EN
        cfg(1'b0, 9'h01A, 12'h0F0);
        chk("rb_rvalid_early", {31'd0, cfg_rvalid}, 32'd0);
        step();
        chk("rb_rvalid", {31'd0, cfg_rvalid}, 32'd1);
        chk("rb_rdata",  {20'd0, cfg_rdata},  32'h5A5);
        step();
        chk("rb_rvalid_pulse", {31'd0, cfg_rvalid}, 32'd0);
        rd("rb_table_1a", 9'h01A, 12'h5A5);
`else
        cfg(1'b0, 9'h01B, 12'h0F0);
        step();
        chk("norb_rvalid", {31'd0, cfg_rvalid}, 32'd0);
        chk("norb_rdata",  {20'd0, cfg_rdata},  32'd0);
        rd("norb_1a", 9'h01A, 12'h5A5);
        rd("norb_we0_writes", 9'h01B, 12'h0F0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
